// File: rtl/bcd_arb_pkg.sv
// State encoding and converter-latency helper shared by the BCD converter arbiter.
package bcd_arb_pkg;

   typedef enum logic [2:0] {
      ST_FLUSH = 3'd0,
      ST_IDLE  = 3'd1,
      ST_START = 3'd2,
      ST_WAIT  = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // Worst-case double-dabble latency, start strobe to data-valid.
   function automatic int conv_latency(input int iw, input int dd);
      return 2*iw + 2*dd*(iw-1) + 3;
   endfunction

endpackage

// File: rtl/bcd_convert_arbiter_rr.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int PW      = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PW-1:0]      ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [PW-1:0]      next_ptr,
   output logic               any
);

   always_comb begin : pick
      logic [PW-1:0] idx;
      idx      = '0;
      gnt      = '0;
      next_ptr = ptr;
      any      = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = PW'((int'(ptr) + i) % NUM_REQ);
         if (!any && req[idx]) begin
            any      = 1'b1;
            gnt[idx] = 1'b1;
            next_ptr = (idx == PW'(NUM_REQ-1)) ? '0 : idx + 1'b1;
         end
      end
   end

endmodule

// File: rtl/bcd_convert_arbiter.sv
// Shares one binary-to-BCD converter between NUM_REQ requesters, round-robin.
// Optional WAIT watchdog: define BCD_ARB_TIMEOUT_EN.
module bcd_convert_arbiter
   import bcd_arb_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int INPUT_WIDTH    = 7,
   parameter int DECIMAL_DIGITS = 3,
   parameter int FLUSH_CYCLES   = 64,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                          i_Clock,
   input  logic                          i_Reset,
   input  logic [NUM_REQ-1:0]            i_Req,
   input  logic [NUM_REQ*INPUT_WIDTH-1:0] i_Binary,
   output logic [NUM_REQ-1:0]            o_Grant,
   output logic [NUM_REQ-1:0]            o_Done,
   output logic                          o_Err,
   output logic [4*DECIMAL_DIGITS-1:0]   o_BCD,
   output logic                          o_Busy,
   output logic [INPUT_WIDTH-1:0]        o_Conv_Binary,
   output logic                          o_Conv_Start,
   input  logic [4*DECIMAL_DIGITS-1:0]   i_Conv_BCD,
   input  logic                          i_Conv_DV
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int FW = $clog2(FLUSH_CYCLES + 1);

   if (FLUSH_CYCLES < conv_latency(INPUT_WIDTH, DECIMAL_DIGITS)) begin : g_bad_flush
      $error("FLUSH_CYCLES shorter than worst-case converter latency");
   end
   if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_nreq
      $error("NUM_REQ must be 2..8");
   end

   state_t                   state, state_nxt;
   logic [FW-1:0]            flush_cnt;
   logic [PW-1:0]            ptr, arb_ptr_nxt;
   logic [NUM_REQ-1:0]       arb_gnt;
   logic                     arb_any;
   logic [INPUT_WIDTH-1:0]   win_bin;
   logic                     flush_done;
   logic                     wdog_hit;
   logic                     err_flag;

   rr_arbiter #(.NUM_REQ(NUM_REQ), .PW(PW)) u_rr (
      .req      (i_Req),
      .ptr      (ptr),
      .gnt      (arb_gnt),
      .next_ptr (arb_ptr_nxt),
      .any      (arb_any)
   );

   always_comb begin
      win_bin = '0;
      for (int k = 0; k < NUM_REQ; k++)
         if (arb_gnt[k]) win_bin = win_bin | i_Binary[k*INPUT_WIDTH +: INPUT_WIDTH];
   end

   assign flush_done = (flush_cnt == FW'(FLUSH_CYCLES-1));

`ifdef BCD_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] wdog;
   logic          err_q;

   assign wdog_hit = (wdog == TW'(TIMEOUT_CYCLES));
   assign err_flag = err_q;

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         wdog  <= '0;
         err_q <= 1'b0;
      end else begin
         wdog <= (state == ST_WAIT) ? wdog + 1'b1 : '0;
         if (state == ST_WAIT && !i_Conv_DV && wdog_hit) err_q <= 1'b1;
         else if (state == ST_DONE)                     err_q <= 1'b0;
      end
   end
`else
   assign wdog_hit = 1'b0;
   assign err_flag = 1'b0;
`endif

   always_ff @(posedge i_Clock) begin
      if (i_Reset) state <= ST_FLUSH;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_FLUSH: if (flush_done) state_nxt = ST_IDLE;
         ST_IDLE:  if (arb_any)    state_nxt = ST_START;
         ST_START: state_nxt = ST_WAIT;
         ST_WAIT:  if (i_Conv_DV || wdog_hit) state_nxt = ST_DONE;
         // A watchdog abort leaves the converter in an unknown state, so drain it again.
         ST_DONE:  state_nxt = err_flag ? ST_FLUSH : ST_IDLE;
         default:  state_nxt = ST_FLUSH;
      endcase
   end

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         flush_cnt     <= '0;
         ptr           <= '0;
         o_Grant       <= '0;
         o_Conv_Binary <= '0;
         o_BCD         <= '0;
      end else begin
         flush_cnt <= (state == ST_FLUSH) ? flush_cnt + 1'b1 : '0;
         if (state == ST_IDLE && arb_any) begin
            o_Grant       <= arb_gnt;
            o_Conv_Binary <= win_bin;
            ptr           <= arb_ptr_nxt;
         end
         if (state == ST_WAIT && i_Conv_DV) o_BCD <= i_Conv_BCD;
         if (state == ST_DONE)              o_Grant <= '0;
      end
   end

   always_comb begin
      o_Busy       = (state != ST_IDLE);
      o_Conv_Start = (state == ST_START);
      o_Done       = (state == ST_DONE) ? o_Grant : '0;
      o_Err        = (state == ST_DONE) && err_flag;
   end

endmodule

// File: tb/tb_bcd_convert_arbiter.sv
// Scoreboard bench for bcd_convert_arbiter with a behavioural converter model.
module tb_bcd_convert_arbiter;

   localparam int NR   = 4;
   localparam int IW   = 7;
   localparam int DD   = 3;
   localparam int FL   = 64;
   localparam int LAT  = 12;

   logic             i_Clock = 1'b0;
   logic             i_Reset;
   logic [NR-1:0]    i_Req;
   logic [NR*IW-1:0] i_Binary;
   logic [NR-1:0]    o_Grant, o_Done;
   logic             o_Err, o_Busy, o_Conv_Start;
   logic [4*DD-1:0]  o_BCD, i_Conv_BCD;
   logic [IW-1:0]    o_Conv_Binary;
   logic             i_Conv_DV;

   always #5 i_Clock = ~i_Clock;

   bcd_convert_arbiter #(
      .NUM_REQ(NR), .INPUT_WIDTH(IW), .DECIMAL_DIGITS(DD),
      .FLUSH_CYCLES(FL), .TIMEOUT_CYCLES(255)
   ) dut (
      .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Req(i_Req), .i_Binary(i_Binary),
      .o_Grant(o_Grant), .o_Done(o_Done), .o_Err(o_Err), .o_BCD(o_BCD),
      .o_Busy(o_Busy), .o_Conv_Binary(o_Conv_Binary), .o_Conv_Start(o_Conv_Start),
      .i_Conv_BCD(i_Conv_BCD), .i_Conv_DV(i_Conv_DV)
   );

   // converter stand-in: fixed latency, one-cycle data-valid
   logic [7:0]      m_cnt = '0;
   logic [IW-1:0]   m_bin = '0;
   logic            m_dv  = 1'b0;
   logic [4*DD-1:0] m_bcd = '0;
   logic            stray_dv = 1'b0;

   function automatic logic [11:0] to_bcd(input logic [IW-1:0] b);
      int v;
      v = int'(b);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   always @(posedge i_Clock) begin
      m_dv <= 1'b0;
      if (o_Conv_Start) begin
         m_cnt <= 8'(LAT);
         m_bin <= o_Conv_Binary;
      end else if (m_cnt != 0) begin
         m_cnt <= m_cnt - 8'd1;
         if (m_cnt == 8'd1) begin
            m_dv  <= 1'b1;
            m_bcd <= to_bcd(m_bin);
         end
      end
   end

   assign i_Conv_DV  = m_dv | stray_dv;
   assign i_Conv_BCD = stray_dv ? 12'hABC : m_bcd;

   typedef struct {
      logic [NR-1:0]   done;
      logic [4*DD-1:0] bcd;
   } exp_t;
   exp_t sb[$];

   int n_checks = 0;
   int n_pass   = 0;
   logic job_active = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
   endtask

   task automatic push(input logic [NR-1:0] d, input logic [11:0] b);
      exp_t e;
      e.done = d;
      e.bcd  = b;
      sb.push_back(e);
   endtask

   // monitor
   always @(negedge i_Clock) begin
      exp_t e;
      if (i_Reset) job_active = 1'b0;
      else begin
         if (o_Conv_Start) begin
            chk("start_while_busy", 32'(job_active), 32'd0);
            job_active = 1'b1;
         end
         if (o_Done != '0) begin
            if (sb.size() == 0) chk("unexpected_done", 32'(o_Done), 32'd0);
            else begin
               e = sb.pop_front();
               chk("done_onehot", 32'(o_Done), 32'(e.done));
               chk("done_bcd",    32'(o_BCD),  32'(e.bcd));
               chk("done_err",    32'(o_Err),  32'd0);
            end
            job_active = 1'b0;
         end
      end
   end

   // counts posedges until o_Conv_Start; optionally pulses a stray DV on the way
   task automatic wait_start(input int stray_at, output int n);
      n = 0;
      for (int i = 0; i < 300; i++) begin
         @(posedge i_Clock); #1;
         n++;
         stray_dv = (n == stray_at);
         if (o_Conv_Start) break;
      end
      stray_dv = 1'b0;
      if (!o_Conv_Start) chk("start_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_idle();
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge i_Clock);
         if (sb.size() == 0 && !o_Busy) begin
            ok = 1'b1;
            break;
         end
      end
      chk("reach_idle", 32'(ok), 32'd1);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      int n, dones;
      i_Reset  = 1'b1;
      i_Req    = '0;
      i_Binary = '0;
      repeat (2) @(posedge i_Clock);
      @(negedge i_Clock);
      chk("rst_busy",  32'(o_Busy),        32'd1);
      chk("rst_grant", 32'(o_Grant),       32'd0);
      chk("rst_done",  32'(o_Done),        32'd0);
      chk("rst_bcd",   32'(o_BCD),         32'd0);
      chk("rst_start", 32'(o_Conv_Start),  32'd0);
      chk("rst_bin",   32'(o_Conv_Binary), 32'd0);
      chk("rst_err",   32'(o_Err),         32'd0);

      // single request through FLUSH, stray DV during FLUSH
      i_Reset = 1'b0;
      i_Req   = 4'b0001;
      i_Binary[0*IW +: IW] = 7'd127;
      push(4'b0001, 12'h127);
      wait_start(5, n);
      chk("flush_latency", 32'(n), 32'(FL + 1));
      chk("grant_single", 32'(o_Grant), 32'h1);
      chk("conv_bin_single", 32'(o_Conv_Binary), 32'd127);
      i_Req = '0;
      wait_idle();

      // stray DV while idle
      @(negedge i_Clock) stray_dv = 1'b1;
      @(negedge i_Clock) stray_dv = 1'b0;
      repeat (3) @(negedge i_Clock);
      chk("bcd_hold_idle", 32'(o_BCD), 32'h127);
      chk("idle_not_busy", 32'(o_Busy), 32'd0);

      // reset mid-WAIT aborts without done, then a fresh conversion
      i_Req = 4'b0100;
      i_Binary[2*IW +: IW] = 7'd50;
      wait_start(-1, n);
      i_Req = '0;
      repeat (4) @(negedge i_Clock);
      i_Reset = 1'b1;
      @(negedge i_Clock);
      i_Reset = 1'b0;
      chk("abort_grant", 32'(o_Grant), 32'd0);
      chk("abort_busy",  32'(o_Busy),  32'd1);
      i_Req = 4'b0100;
      push(4'b0100, 12'h050);
      wait_start(-1, n);
      chk("reflush_latency", 32'(n), 32'(FL + 1));
      i_Req = '0;
      wait_idle();

      // all four requesting: rotation from index 0
      @(negedge i_Clock) i_Reset = 1'b1;
      @(negedge i_Clock) i_Reset = 1'b0;
      i_Binary = {7'd100, 7'd99, 7'd42, 7'd5};
      i_Req    = 4'b1111;
      push(4'b0001, 12'h005);
      push(4'b0010, 12'h042);
      push(4'b0100, 12'h099);
      push(4'b1000, 12'h100);
      push(4'b0001, 12'h005);
      dones = 0;
      for (int i = 0; i < 3000 && dones < 5; i++) begin
         @(negedge i_Clock);
         if (o_Done != '0) dones++;
      end
      i_Req = '0;
      chk("rotation_dones", 32'(dones), 32'd5);
      wait_idle();

      // operand changes after grant; captured value must win
      i_Binary[2*IW +: IW] = 7'd64;
      i_Req = 4'b0100;
      push(4'b0100, 12'h064);
      wait_start(-1, n);
      i_Binary[2*IW +: IW] = 7'd3;
      i_Req = '0;
      wait_idle();
      chk("bcd_after_capture", 32'(o_BCD), 32'h064);

      repeat (5) @(negedge i_Clock);
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
